// File: rtl/tm_step_controller.sv
// Sequencing controller for the TuringMachine core: conditions the raw buttons and drives
// the core's Next/Done pulse protocol through load, hand-off, stepping/free-run and halt.
module tm_step_controller #(
  parameter int                 STATE_W    = 6,
  parameter logic [STATE_W-1:0] HALT_STATE = 6'd63,
  parameter int                 PULSE_LEN  = 2,
  parameter int                 GAP_LEN    = 4,
  parameter int                 DIV_W      = 8,
  parameter int                 CNT_W      = 8
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               next_btn,
  input  logic               done_btn,
  input  logic               auto_run,
  input  logic [DIV_W-1:0]   run_period,
  input  logic [STATE_W-1:0] tm_state,
  output logic               Next,
  output logic               Done,
  output logic [1:0]         mode,
  output logic               busy,
  output logic [CNT_W-1:0]   load_count,
  output logic [CNT_W-1:0]   step_count
);

  localparam int LEN_W = 8;
  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_HALT = 2'd2;

  // Handshake: a request is taken only in ENG_IDLE; anything arriving while busy is dropped.
  typedef enum logic [1:0] {ENG_IDLE, ENG_PULSE, ENG_GAP} eng_t;

  eng_t             eng_q, eng_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             kind_done_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] timer_q;
  logic [CNT_W-1:0] load_q, step_q;

  logic next_s1, next_s2, next_prev, next_edge;
  logic done_s1, done_s2, done_prev, done_edge;

  logic             start, start_done, gap_end, auto_fire;
  logic [DIV_W-1:0] period_eff;

  // Two-flop synchronizers followed by a registered rising-edge detector.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      next_s1 <= 1'b0; next_s2 <= 1'b0; next_prev <= 1'b0; next_edge <= 1'b0;
      done_s1 <= 1'b0; done_s2 <= 1'b0; done_prev <= 1'b0; done_edge <= 1'b0;
    end else begin
      next_s1   <= next_btn;
      next_s2   <= next_s1;
      next_prev <= next_s2;
      next_edge <= next_s2 & ~next_prev;
      done_s1   <= done_btn;
      done_s2   <= done_s1;
      done_prev <= done_s2;
      done_edge <= done_s2 & ~done_prev;
    end
  end

  assign period_eff = (run_period == '0) ? DIV_W'(1) : run_period;
  assign auto_fire  = (eng_q == ENG_IDLE) && (mode_q == MODE_RUN) && auto_run &&
                      (timer_q == DIV_W'(1));

  always_comb begin
    eng_d      = eng_q;
    len_d      = len_q;
    start      = 1'b0;
    start_done = 1'b0;
    gap_end    = 1'b0;
    case (eng_q)
      ENG_IDLE: begin
        // Done outranks Next when both edges land in the same LOAD cycle.
        if (mode_q == MODE_LOAD && done_edge) begin
          start      = 1'b1;
          start_done = 1'b1;
        end else if (mode_q == MODE_LOAD && next_edge) begin
          start = 1'b1;
        end else if (mode_q == MODE_RUN && (next_edge || auto_fire)) begin
          start = 1'b1;
        end
        if (start) begin
          eng_d = ENG_PULSE;
          len_d = LEN_W'(PULSE_LEN - 1);
        end
      end
      ENG_PULSE: begin
        if (len_q == '0) begin
          eng_d = ENG_GAP;
          len_d = LEN_W'(GAP_LEN - 1);
        end else begin
          len_d = len_q - LEN_W'(1);
        end
      end
      ENG_GAP: begin
        if (len_q == '0) begin
          eng_d   = ENG_IDLE;
          gap_end = 1'b1;
        end else begin
          len_d = len_q - LEN_W'(1);
        end
      end
      default: eng_d = ENG_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      eng_q       <= ENG_IDLE;
      len_q       <= '0;
      kind_done_q <= 1'b0;
    end else begin
      eng_q <= eng_d;
      len_q <= len_d;
      if (start) kind_done_q <= start_done;
    end
  end

  // Mode moves only on the edge that closes GAP; the halt check samples tm_state there.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      mode_q <= MODE_LOAD;
    end else if (gap_end) begin
      if (kind_done_q && mode_q == MODE_LOAD)
        mode_q <= MODE_RUN;
      else if (!kind_done_q && mode_q == MODE_RUN && tm_state == HALT_STATE)
        mode_q <= MODE_HALT;
    end
  end

  // Interval timer: reloaded on IDLE entry, counts IDLE cycles, fires on its last count.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      timer_q <= '0;
    end else if (!auto_run || mode_q != MODE_RUN) begin
      timer_q <= '0;
    end else if (gap_end) begin
      timer_q <= period_eff;
    end else if (eng_q == ENG_IDLE) begin
      if (timer_q == '0) timer_q <= period_eff;
      else               timer_q <= timer_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      load_q <= '0;
      step_q <= '0;
    end else if (start && !start_done) begin
      if (mode_q == MODE_LOAD && load_q != '1) load_q <= load_q + CNT_W'(1);
      if (mode_q == MODE_RUN  && step_q != '1) step_q <= step_q + CNT_W'(1);
    end
  end

  assign Next       = (eng_q == ENG_PULSE) && !kind_done_q;
  assign Done       = (eng_q == ENG_PULSE) &&  kind_done_q;
  assign busy       = (eng_q != ENG_IDLE);
  assign mode       = mode_q;
  assign load_count = load_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_tm_step_controller.sv
// Bench for tm_step_controller: directed/randomized button traffic against a
// transaction-level model of pulse times, counts and mode, on 8-bit and 4-bit counter builds.
module tb_tm_step_controller;
  localparam int P = 2;
  localparam int G = 4;

  logic       clock = 1'b0;
  logic       Reset, next_btn, done_btn, auto_run;
  logic [7:0] run_period;
  logic [5:0] tm_state;

  logic       nxt, dn, busy, nxt4, dn4, busy4;
  logic [1:0] mode, mode4;
  logic [7:0] load_count, step_count;
  logic [3:0] load4, step4;

  tm_step_controller dut (
    .clock(clock), .Reset(Reset), .next_btn(next_btn), .done_btn(done_btn),
    .auto_run(auto_run), .run_period(run_period), .tm_state(tm_state),
    .Next(nxt), .Done(dn), .mode(mode), .busy(busy),
    .load_count(load_count), .step_count(step_count)
  );

  tm_step_controller #(.CNT_W(4)) dut4 (
    .clock(clock), .Reset(Reset), .next_btn(next_btn), .done_btn(done_btn),
    .auto_run(auto_run), .run_period(run_period), .tm_state(tm_state),
    .Next(nxt4), .Done(dn4), .mode(mode4), .busy(busy4),
    .load_count(load4), .step_count(step4)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observed pulse rise times/widths and the scoreboard's expected rise times.
  logic [31:0] nxt_rise_q[$], done_rise_q[$], width_q[$];
  logic [31:0] exp_next_q[$], exp_done_q[$];

  logic prev_n = 1'b0, prev_d = 1'b0;
  int   len_n = 0, len_d = 0;
  always @(negedge clock) begin
    if (nxt || dn) chk("next_done_exclusive", 32'(nxt & dn), 32'd0);
    if (nxt && !prev_n) nxt_rise_q.push_back(32'(cyc));
    if (dn && !prev_d)  done_rise_q.push_back(32'(cyc));
    if (nxt) len_n++;
    else if (prev_n) begin width_q.push_back(32'(len_n)); len_n = 0; end
    if (dn) len_d++;
    else if (prev_d) begin width_q.push_back(32'(len_d)); len_d = 0; end
    prev_n = nxt;
    prev_d = dn;
  end

  // Reference model: mode, counts and the earliest cycle a new pulse may rise.
  int m_mode, m_load, m_step, m_load4, m_step4, m_free;

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_mode = 0; m_load = 0; m_step = 0; m_load4 = 0; m_step4 = 0; m_free = 0;
    nxt_rise_q.delete(); done_rise_q.delete(); width_q.delete();
    exp_next_q.delete(); exp_done_q.delete();
  endtask

  task automatic model_next(input int t);
    exp_next_q.push_back(32'(t));
    m_free = t + P + G + 1;
    if (m_mode == 0) begin
      m_load = sat(m_load, 255); m_load4 = sat(m_load4, 15);
    end else begin
      m_step = sat(m_step, 255); m_step4 = sat(m_step4, 15);
      if (tm_state == 6'd63) m_mode = 2;
    end
  endtask

  task automatic model_req(input bit nx, input bit de, input int t);
    if (m_mode == 2 || t < m_free) return;
    if (m_mode == 0 && de) begin
      exp_done_q.push_back(32'(t));
      m_free = t + P + G + 1;
      m_mode = 1;
    end else if (nx) begin
      model_next(t);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clock); #2; end
  endtask

  // Buttons are driven just after a falling edge; the first sampling edge is cyc+1.
  task automatic press(input bit nx, input bit de, input int hold);
    model_req(nx, de, cyc + 4);
    next_btn = nx;
    done_btn = de;
    tick(hold);
    next_btn = 1'b0;
    done_btn = 1'b0;
  endtask

  task automatic check_phase(input string tag);
    chk({tag, "_next_n"}, 32'(nxt_rise_q.size()), 32'(exp_next_q.size()));
    for (int i = 0; i < exp_next_q.size() && i < nxt_rise_q.size(); i++)
      chk({tag, "_next_t"}, nxt_rise_q[i], exp_next_q[i]);
    chk({tag, "_done_n"}, 32'(done_rise_q.size()), 32'(exp_done_q.size()));
    for (int i = 0; i < exp_done_q.size() && i < done_rise_q.size(); i++)
      chk({tag, "_done_t"}, done_rise_q[i], exp_done_q[i]);
    foreach (width_q[i]) chk({tag, "_width"}, width_q[i], 32'(P));
    chk({tag, "_load"},  32'(load_count), 32'(m_load));
    chk({tag, "_step"},  32'(step_count), 32'(m_step));
    chk({tag, "_load4"}, 32'(load4), 32'(m_load4));
    chk({tag, "_step4"}, 32'(step4), 32'(m_step4));
    chk({tag, "_mode"},  32'(mode),  32'(m_mode));
    chk({tag, "_mode4"}, 32'(mode4), 32'(m_mode4_fn()));
    nxt_rise_q.delete(); done_rise_q.delete(); width_q.delete();
    exp_next_q.delete(); exp_done_q.delete();
  endtask

  function automatic int m_mode4_fn();
    return m_mode;
  endfunction

  initial begin
    int h, g, used, t, f;
    Reset = 1'b1; next_btn = 1'b0; done_btn = 1'b0; auto_run = 1'b0;
    run_period = 8'd3; tm_state = 6'd0;
    model_clear();
    tick(3);
    Reset = 1'b0;
    tick(2);

    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_next", 32'(nxt), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
    chk("rst_load", 32'(load_count), 32'd0);
    chk("rst_step", 32'(step_count), 32'd0);

    // Asynchronous reset in the middle of a Next pulse.
    press(1'b1, 1'b0, 1);
    tick(3);
    chk("mid_next", 32'(nxt), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_load", 32'(load_count), 32'(m_load));
    Reset = 1'b1;
    #1;
    chk("arst_next", 32'(nxt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_load", 32'(load_count), 32'd0);
    chk("arst_step", 32'(step_count), 32'd0);
    tick(2);
    model_clear();
    Reset = 1'b0;
    tick(2);

    // A button held for 20 cycles yields exactly one pulse.
    press(1'b1, 1'b0, 20);
    tick(10);
    check_phase("hold");

    // Load: 27 more spaced presses, some followed by a press that lands while busy.
    for (int i = 0; i < 27; i++) begin
      h = $urandom_range(1, 3);
      g = $urandom_range(10, 14);
      press(1'b1, 1'b0, h);
      used = h;
      if ($urandom_range(0, 2) == 0) begin
        tick(1);
        press(1'b1, 1'b0, 1);
        used += 2;
      end
      tick(g - used);
    end
    tick(6);
    chk("load28", 32'(load_count), 32'd28);
    check_phase("load");

    // Simultaneous next/done in LOAD: Done wins, mode flips to RUN six cycles after Done rises.
    t = cyc + 4;
    press(1'b1, 1'b1, 2);
    tick(t + 5 - cyc);
    chk("handoff_mode_before", 32'(mode), 32'd0);
    tick(1);
    chk("handoff_mode_after", 32'(mode), 32'd1);
    tick(4);
    check_phase("handoff");
    chk("handoff_step", 32'(step_count), 32'd0);

    // RUN: random steps with drops while busy and ignored done presses.
    for (int i = 0; i < 20; i++) begin
      tm_state = 6'($urandom_range(0, 62));
      h = $urandom_range(1, 3);
      g = $urandom_range(12, 16);
      press(1'b1, 1'($urandom_range(0, 1)), h);
      used = h;
      if ($urandom_range(0, 2) == 0) begin
        tick(1);
        press(1'b1, 1'b0, 1);
        used += 2;
      end
      if ($urandom_range(0, 2) == 0) begin
        tick(1);
        press(1'b0, 1'b1, 1);
        used += 2;
      end
      tick(g - used);
    end
    tick(6);
    chk("run_step20", 32'(step_count), 32'd20);
    chk("run_step4_sat", 32'(step4), 32'd15);
    chk("load4_sat", 32'(load4), 32'd15);
    check_phase("run");

    // Auto-run: period 3 gives a 9-cycle cadence, period 0 a 7-cycle cadence.
    tm_state = 6'd5;
    run_period = 8'd3;
    auto_run = 1'b1;
    for (int i = 0; i < 40 && nxt_rise_q.size() == 0; i++) tick(1);
    if (nxt_rise_q.size() == 0) begin
      chk("auto_start", 32'd0, 32'd1);
      auto_run = 1'b0;
      tick(10);
    end else begin
      f = cyc;
      for (int j = 0; j < 4; j++) model_next(f + 9 * j);
      for (int j = 1; j <= 3; j++) model_next(f + 27 + 7 * j);
      tick(28);
      run_period = 8'd0;
      tick(21);
      auto_run = 1'b0;
    end
    tick(30);
    check_phase("auto");

    // Halt: the step sampled with tm_state=63 moves to HALT; everything afterwards is ignored.
    tm_state = 6'd63;
    t = cyc + 4;
    press(1'b1, 1'b0, 1);
    tick(t + 5 - cyc);
    chk("halt_mode_before", 32'(mode), 32'd1);
    tick(1);
    chk("halt_mode_after", 32'(mode), 32'd2);
    tick(4);
    press(1'b1, 1'b0, 2);
    tick(8);
    press(1'b0, 1'b1, 2);
    tick(8);
    press(1'b1, 1'b1, 2);
    tick(8);
    run_period = 8'd1;
    auto_run = 1'b1;
    tick(30);
    auto_run = 1'b0;
    check_phase("halt");

    // HALT clears only on reset.
    Reset = 1'b1;
    tick(1);
    chk("final_rst_mode", 32'(mode), 32'd0);
    chk("final_rst_step", 32'(step_count), 32'd0);
    Reset = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
